idp_ctrl: RTL and testbench
===========================

Name: idp_ctrl

Overview:
- Multi-cycle control sequencer that drives the control inputs of the processor's integrated datapath (register file + ALU).
- Fetches instruction words from instruction memory over a request/valid handshake and decodes them into datapath controls: register addresses, ALU opcode, operand-mux select, immediate and write enable.
- Captures the datapath's N/Z/C outputs and uses them for conditional branches.

Parameters:
- PC_W, 8, program counter / instruction address width
- INSTR_W, 20, instruction word width; fixed format below, only 20 supported

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching at pc=0
- fetch_req  out  1  instruction request, held until accepted
- pc  out  PC_W  instruction address, valid while fetch_req=1
- instr_valid  in  1  instr_data valid; accepted when fetch_req=1
- instr_data  in  INSTR_W  instruction word
- N, Z, C  in  1 each  datapath ALU flags
- en  out  1  register-file write enable
- sel  out  1  1 = second ALU operand from secin
- write_add, fir_add, sec_add  out  3 each  register addresses
- opcode  out  4  ALU opcode
- secin  out  16  immediate operand
- halted  out  1  HALT state reached

Behaviour:
- Instruction format:
  - [19:18] class: 00 ALU reg-reg, 01 ALU reg-imm, 10 branch, 11 system.
  - ALU: [17:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2; reg-imm uses [7:0] imm8, sign-extended to 16 on secin.
  - Branch: [15:14] cond (00 always, 01 Z, 10 N, 11 C), [7:0] signed offset.
  - System: [17]=1 HALT, else NOP.
- Reset (asynchronous, rst=0):
  - state IDLE; pc=0; flag register=0.
  - All outputs 0, including en and fetch_req, immediately, even mid-instruction.
- FSM:
  - IDLE: start=1 -> FETCH.
  - FETCH: fetch_req=1 with pc stable. On instr_valid=1, latch instr_data -> DECODE. instr_valid while fetch_req=0 is ignored.
  - DECODE: registered controls take their decoded values; en=0.
    - reg-reg: sel=0.
    - reg-imm: sel=1, sec_add=0.
    - branch/system: controls hold previous values, en stays 0.
    - Next state EXEC.
  - EXEC: controls unchanged from DECODE.
    - ALU class: en=1 for exactly this cycle; N/Z/C latched into the flag register at its end; pc<=pc+1.
    - Branch: if cond is true on the flag register, pc<=pc+1+sext(offset); else pc<=pc+1. Flags unchanged.
    - NOP: pc+1.
    - HALT: pc unchanged, -> HALT; otherwise -> FETCH.
  - HALT: halted=1, en=0, fetch_req=0; exit only by reset. start is ignored.
- Timing:
  - ALU instruction takes 3 cycles plus fetch wait; minimum 3 cycles/instruction with zero-wait memory (instr_valid=1 in the first FETCH cycle).
  - en is never asserted outside EXEC.
- pc arithmetic is modulo 2^PC_W; increment and branch targets wrap silently (pc=255 +1 -> 0; pc=2, offset -5 -> 254).
- Branch flags are those of the most recent completed ALU instruction, not combinational N/Z/C.
- start asserted outside IDLE has no effect.

Optional Feature:
- Macro: IDP_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After each EXEC that goes to FETCH, the FSM enters PAUSE instead; fetch_req=0 and en=0 in PAUSE.
  - A step=1 cycle moves PAUSE -> FETCH. step in other states is ignored.
  - The first fetch after IDLE needs no step.
- Undefined: no step port, no PAUSE state; EXEC -> FETCH directly.

Decomposition:
- Package idp_ctrl_pkg holds:
  - state encoding (IDLE, FETCH, DECODE, EXEC, HALT, PAUSE);
  - class codes and branch cond codes;
  - instruction field bit positions;
  - the imm sign-extension function.
- One combinational sub-module, idp_ctrl_dec: instruction word -> opcode, addresses, sel, secin, is_alu, is_branch, is_halt, cond, offset.
- The FSM, pc and flag register live in idp_ctrl.

Test Plan:
- Reset, then start, zero-wait memory; instr 0x0_4A28 (reg-reg, op=1, rd=1, rs1=2, rs2=1) -> fetch_req at pc=0; DECODE sel=0, fir_add=2, sec_add=1, write_add=1, opcode=1; en=1 for exactly one cycle; next fetch pc=1.
- Reg-imm with imm8=0xFB -> secin=0xFFFB, sel=1 through DECODE and EXEC.
- ALU op returning Z=1, then branch cond=01 offset=+3 at pc=1 -> next pc=5; same sequence with Z=0 -> pc=2.
- instr_valid delayed 4 cycles -> fetch_req and pc held steady, en=0 throughout; instr_valid pulsed during DECODE -> ignored.
- Branch at pc=255, cond=always, offset=0 -> next fetch pc=0; HALT instruction -> halted=1, fetch_req stays 0, start ignored.
- rst low during EXEC with en=1 -> en, fetch_req and pc go 0 without a clock edge; IDP_CTRL_SINGLE_STEP_EN build: no fetch after the first instruction until step=1.

Source files
------------

// File: rtl/idp_ctrl_pkg.sv
// Shared definitions for the idp_ctrl sequencer: state encodings, instruction
// class / branch condition codes, instruction field positions and the
// immediate sign-extension helper.
package idp_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;

  typedef enum logic [1:0] {
    CLS_ALU_RR = 2'b00,
    CLS_ALU_RI = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_SYS    = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_N      = 2'b10,
    COND_C      = 2'b11
  } cond_e;

  // Instruction field bit positions
  localparam int unsigned CLS_HI   = 19;
  localparam int unsigned CLS_LO   = 18;
  localparam int unsigned OP_HI    = 17;
  localparam int unsigned OP_LO    = 14;
  localparam int unsigned RD_HI    = 13;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned RS1_HI   = 10;
  localparam int unsigned RS1_LO   = 8;
  localparam int unsigned RS2_HI   = 7;
  localparam int unsigned RS2_LO   = 5;
  localparam int unsigned IMM_HI   = 7;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned COND_HI  = 15;
  localparam int unsigned COND_LO  = 14;
  localparam int unsigned HALT_BIT = 17;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/idp_ctrl_if.sv
// Instruction-memory fetch handshake between idp_ctrl (master) and the
// instruction memory (slave).
interface idp_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
);
  logic               fetch_req;
  logic [PC_W-1:0]    pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;

  modport master (
    output fetch_req,
    output pc,
    input  instr_valid,
    input  instr_data
  );

  modport slave (
    input  fetch_req,
    input  pc,
    output instr_valid,
    output instr_data
  );
endinterface

// File: rtl/idp_ctrl_dec.sv
// Combinational instruction decoder: splits a 20-bit instruction word into
// datapath controls and sequencing information.
module idp_ctrl_dec
  import idp_ctrl_pkg::*;
#(
  parameter int INSTR_W = 20
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         opcode_o,
  output logic [2:0]         write_add_o,
  output logic [2:0]         fir_add_o,
  output logic [2:0]         sec_add_o,
  output logic               sel_o,
  output logic [15:0]        secin_o,
  output logic               is_alu_o,
  output logic               is_branch_o,
  output logic               is_halt_o,
  output logic [1:0]         cond_o,
  output logic [7:0]         offset_o
);

  cls_e cls;

  // Field extraction and class decode
  always_comb begin
    cls         = cls_e'(instr_i[CLS_HI:CLS_LO]);
    opcode_o    = instr_i[OP_HI:OP_LO];
    write_add_o = instr_i[RD_HI:RD_LO];
    fir_add_o   = instr_i[RS1_HI:RS1_LO];
    is_alu_o    = (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI);
    sel_o       = (cls == CLS_ALU_RI);
    sec_add_o   = sel_o ? '0 : instr_i[RS2_HI:RS2_LO];
    secin_o     = sext8(instr_i[IMM_HI:IMM_LO]);
    is_branch_o = (cls == CLS_BRANCH);
    is_halt_o   = (cls == CLS_SYS) && instr_i[HALT_BIT];
    cond_o      = instr_i[COND_HI:COND_LO];
    offset_o    = instr_i[IMM_HI:IMM_LO];
  end

endmodule

// File: rtl/idp_ctrl.sv
// idp_ctrl: multi-cycle IDLE/FETCH/DECODE/EXEC/HALT sequencer driving the
// register-file + ALU datapath. Holds pc, the N/Z/C flag register and the
// registered datapath controls.
// Optional build macro IDP_CTRL_SINGLE_STEP_EN adds a step input and a PAUSE
// state between EXEC and the next FETCH.
module idp_ctrl
  import idp_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef IDP_CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  idp_ctrl_if.master  bus,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic        en,
  output logic        sel,
  output logic [2:0]  write_add,
  output logic [2:0]  fir_add,
  output logic [2:0]  sec_add,
  output logic [3:0]  opcode,
  output logic [15:0] secin,
  output logic        halted
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      flags_q, flags_d;   // {N, Z, C}

  logic            is_alu_q, is_branch_q, is_halt_q;
  logic [1:0]      cond_q;
  logic [7:0]      offset_q;

  logic [2:0]      write_add_q, fir_add_q, sec_add_q;
  logic [3:0]      opcode_q;
  logic            sel_q;
  logic [15:0]     secin_q;

  logic [3:0]      dec_opcode;
  logic [2:0]      dec_write_add, dec_fir_add, dec_sec_add;
  logic            dec_sel, dec_is_alu, dec_is_branch, dec_is_halt;
  logic [15:0]     dec_secin;
  logic [1:0]      dec_cond;
  logic [7:0]      dec_offset;

  logic            accept;
  logic            taken;
  logic            step_go;
  logic [15:0]     off16;

`ifdef IDP_CTRL_SINGLE_STEP_EN
  assign step_go = step;
`else
  assign step_go = 1'b1;
`endif

  assign accept = (state_q == S_FETCH) && bus.instr_valid;
  // Branch offset is sign-extended to 16 bits then truncated; PC_W <= 16.
  assign off16  = sext8(offset_q);

  idp_ctrl_dec #(.INSTR_W(INSTR_W)) u_dec (
    .instr_i     (bus.instr_data),
    .opcode_o    (dec_opcode),
    .write_add_o (dec_write_add),
    .fir_add_o   (dec_fir_add),
    .sec_add_o   (dec_sec_add),
    .sel_o       (dec_sel),
    .secin_o     (dec_secin),
    .is_alu_o    (dec_is_alu),
    .is_branch_o (dec_is_branch),
    .is_halt_o   (dec_is_halt),
    .cond_o      (dec_cond),
    .offset_o    (dec_offset)
  );

  // Branch condition evaluated on the registered flags
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond_q))
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags_q[1];
      COND_N:      taken = flags_q[2];
      COND_C:      taken = flags_q[0];
      default:     taken = 1'b0;
    endcase
  end

  // Next-state, pc and flag update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt_q) begin
          state_d = S_HALT;
        end else begin
`ifdef IDP_CTRL_SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
          if (is_branch_q && taken) pc_d = pc_q + PC_W'(1) + off16[PC_W-1:0];
          else                      pc_d = pc_q + PC_W'(1);
          if (is_alu_q) flags_d = {N, Z, C};
        end
      end
      S_HALT:   state_d = S_HALT;
      S_PAUSE:  if (step_go) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, pc and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // Capture the accepted instruction; datapath controls are loaded on the
  // accept edge so their decoded values are already visible during DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_alu_q    <= 1'b0;
      is_branch_q <= 1'b0;
      is_halt_q   <= 1'b0;
      cond_q      <= '0;
      offset_q    <= '0;
      write_add_q <= '0;
      fir_add_q   <= '0;
      sec_add_q   <= '0;
      opcode_q    <= '0;
      sel_q       <= 1'b0;
      secin_q     <= '0;
    end else if (accept) begin
      is_alu_q    <= dec_is_alu;
      is_branch_q <= dec_is_branch;
      is_halt_q   <= dec_is_halt;
      cond_q      <= dec_cond;
      offset_q    <= dec_offset;
      if (dec_is_alu) begin
        write_add_q <= dec_write_add;
        fir_add_q   <= dec_fir_add;
        sec_add_q   <= dec_sec_add;
        opcode_q    <= dec_opcode;
        sel_q       <= dec_sel;
        secin_q     <= dec_secin;
      end
    end
  end

  assign bus.fetch_req = (state_q == S_FETCH);
  assign bus.pc        = pc_q;
  assign en            = (state_q == S_EXEC) && is_alu_q;
  assign halted        = (state_q == S_HALT);
  assign sel           = sel_q;
  assign write_add     = write_add_q;
  assign fir_add       = fir_add_q;
  assign sec_add       = sec_add_q;
  assign opcode        = opcode_q;
  assign secin         = secin_q;

endmodule

// File: tb/tb_idp_ctrl.sv
// Self-checking bench for idp_ctrl: directed program plus a random program,
// compared against an instruction-level reference model.
module tb_idp_ctrl;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic N = 1'b0, Z = 1'b0, C = 1'b0;
`ifdef IDP_CTRL_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic        en, sel, halted;
  logic [2:0]  write_add, fir_add, sec_add;
  logic [3:0]  opcode;
  logic [15:0] secin;

  idp_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  idp_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef IDP_CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .en        (en),
    .sel       (sel),
    .write_add (write_add),
    .fir_add   (fir_add),
    .sec_add   (sec_add),
    .opcode    (opcode),
    .secin     (secin),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [19:0] mem [256];

  // Reference model state: architectural pc, flags and last ALU controls
  int          m_pc;
  logic [2:0]  m_flags;
  logic [2:0]  m_wa, m_fa, m_sa;
  logic [3:0]  m_op;
  logic        m_sel;
  logic [15:0] m_secin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_flags = '0;
    m_wa = '0; m_fa = '0; m_sa = '0; m_op = '0; m_sel = 1'b0; m_secin = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},    32'(bus.fetch_req), 32'd0);
    chk({tag, "_pc"},     32'(bus.pc),        32'd0);
    chk({tag, "_en"},     32'(en),            32'd0);
    chk({tag, "_sel"},    32'(sel),           32'd0);
    chk({tag, "_wa"},     32'(write_add),     32'd0);
    chk({tag, "_fa"},     32'(fir_add),       32'd0);
    chk({tag, "_sa"},     32'(sec_add),       32'd0);
    chk({tag, "_op"},     32'(opcode),        32'd0);
    chk({tag, "_secin"},  32'(secin),         32'd0);
    chk({tag, "_halted"}, 32'(halted),        32'd0);
  endtask

  task automatic chk_ctl(input string tag);
    chk({tag, "_wa"},  32'(write_add), 32'(m_wa));
    chk({tag, "_fa"},  32'(fir_add),   32'(m_fa));
    chk({tag, "_sa"},  32'(sec_add),   32'(m_sa));
    chk({tag, "_op"},  32'(opcode),    32'(m_op));
    chk({tag, "_sel"}, 32'(sel),       32'(m_sel));
    if (m_sel) chk({tag, "_secin"}, 32'(secin), 32'(m_secin));
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; bus.instr_valid = 1'b0; bus.instr_data = '0;
    {N, Z, C} = 3'b000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One instruction: fetch (with wcyc wait cycles), decode, execute.
  task automatic run_instr(input int unsigned wcyc, input bit pulse, input logic [2:0] nzc);
    logic [19:0] w;
    logic [1:0]  cls;
    logic        is_alu, is_br, is_halt, taken;
    int          off, guard;
    guard = 0;
    while (bus.fetch_req !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    chk("fetch_req", 32'(bus.fetch_req), 32'd1);
    chk("fetch_pc",  32'(bus.pc),        32'(m_pc));
    chk("fetch_en",  32'(en),            32'd0);
    w       = mem[m_pc];
    cls     = w[19:18];
    is_alu  = (cls[1] == 1'b0);
    is_br   = (cls == 2'b10);
    is_halt = (cls == 2'b11) && w[17];
    for (int unsigned i = 0; i < wcyc; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(bus.fetch_req), 32'd1);
      chk("wait_pc",  32'(bus.pc),        32'(m_pc));
      chk("wait_en",  32'(en),            32'd0);
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    @(negedge clk);
    if (is_alu) begin
      m_op  = w[17:14];
      m_wa  = w[13:11];
      m_fa  = w[10:8];
      m_sel = cls[0];
      m_sa  = m_sel ? 3'd0 : w[7:5];
      if (m_sel) m_secin = {{8{w[7]}}, w[7:0]};
    end
    bus.instr_valid = pulse;
    bus.instr_data  = 20'($urandom);
    chk_ctl("dec");
    chk("dec_en",  32'(en),            32'd0);
    chk("dec_req", 32'(bus.fetch_req), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk_ctl("exec");
    chk("exec_en",     32'(en),            32'(is_alu));
    chk("exec_req",    32'(bus.fetch_req), 32'd0);
    chk("exec_halted", 32'(halted),        32'd0);
    {N, Z, C} = nzc;
    taken = 1'b0;
    off   = int'($signed(w[7:0]));
    if (is_br) begin
      case (w[15:14])
        2'b00:   taken = 1'b1;
        2'b01:   taken = m_flags[1];
        2'b10:   taken = m_flags[2];
        default: taken = m_flags[0];
      endcase
    end
    if (is_alu) m_flags = nzc;
    if (!is_halt) m_pc = (m_pc + 1 + (taken ? off : 0)) & 255;
    @(negedge clk);
    if (is_halt) begin
      chk("halt_halted", 32'(halted),        32'd1);
      chk("halt_req",    32'(bus.fetch_req), 32'd0);
      chk("halt_pc",     32'(bus.pc),        32'(m_pc));
    end else begin
`ifdef IDP_CTRL_SINGLE_STEP_EN
      chk("pause_req", 32'(bus.fetch_req), 32'd0);
      chk("pause_en",  32'(en),            32'd0);
      @(negedge clk);
      chk("pause_hold", 32'(bus.fetch_req), 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 20'hC0000;
    mem[0]   = 20'h04A28;                               // rr op1 rd1 rs1=2 rs2=1
    mem[1]   = {2'b01, 4'd3, 3'd5, 3'd6, 8'hFB};        // ri imm -5
    mem[2]   = {2'b00, 4'd2, 3'd3, 3'd4, 3'd7, 5'd0};   // rr, Z result
    mem[3]   = {2'b10, 2'b00, 2'b01, 6'd0, 8'd3};       // bz +3 taken -> 7
    mem[7]   = {2'b00, 4'd5, 3'd7, 3'd1, 3'd2, 5'd0};   // rr, Z=0
    mem[8]   = {2'b10, 2'b00, 2'b01, 6'd0, 8'd3};       // bz +3 not taken -> 9
    mem[9]   = {2'b10, 2'b00, 2'b00, 6'd0, 8'hF5};      // b -11 -> 255
    mem[255] = {2'b10, 2'b00, 2'b00, 6'd0, 8'd11};      // b +11 wraps -> 11
    mem[12]  = {2'b10, 2'b00, 2'b10, 6'd0, 8'd5};       // bn not taken -> 13
    mem[13]  = 20'hE0000;                               // HALT

    // Reset values, then IDLE ignores instr_valid
    do_reset();
    chk_zero("rst");
    bus.instr_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_req", 32'(bus.fetch_req), 32'd0);
      chk("idle_pc",  32'(bus.pc),        32'd0);
    end
    bus.instr_valid = 1'b0;

    // Directed program
    do_start();
    run_instr(0, 1'b0, 3'b100);
    run_instr(4, 1'b1, 3'b001);
    run_instr(0, 1'b0, 3'b010);
    run_instr(1, 1'b0, 3'b000);
    run_instr(0, 1'b1, 3'b000);
    run_instr(0, 1'b0, 3'b111);
    run_instr(2, 1'b0, 3'b000);
    run_instr(0, 1'b0, 3'b000);
    run_instr(0, 1'b0, 3'b000);
    run_instr(0, 1'b0, 3'b111);
    run_instr(0, 1'b0, 3'b000);
    start = 1'b1;
    bus.instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_stay",     32'(halted),        32'd1);
      chk("halt_stay_req", 32'(bus.fetch_req), 32'd0);
      chk("halt_stay_en",  32'(en),            32'd0);
      chk("halt_stay_pc",  32'(bus.pc),        32'd13);
    end
    start = 1'b0;
    bus.instr_valid = 1'b0;

    // Asynchronous reset in the middle of an ALU EXEC
    do_reset();
    do_start();
    run_instr(0, 1'b0, 3'b000);
    chk("pre_fetch_pc", 32'(bus.pc), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_data  = mem[1];
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", 32'(en), 32'd1);
    #2 rst = 1'b0;
    #1 chk_zero("async");
    do_reset();

    // Random program
    for (int i = 0; i < 256; i++) begin
      logic [19:0] w;
      w = 20'($urandom);
      if (w[19:18] == 2'b11) w[17] = 1'b0;
      mem[i] = w;
    end
    do_start();
    for (int k = 0; k < 60; k++)
      run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
